// File: rtl/pe_os_stream.sv
// Output-stationary systolic PE: forwards A east / B south and accumulates signed A*B over a K-length tile.
// Optional PE_ACC_SAT_EN: saturating accumulation with a sticky sat flag; otherwise accumulation wraps.
module pe_os_stream #(
   parameter  int DW    = 8,
   parameter  int AW    = 24,
   parameter  int K_MAX = 255,
   localparam int CW    = $clog2(K_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] a_in,
   input  logic          a_vld_in,
   input  logic [DW-1:0] b_in,
   input  logic          b_vld_in,
   output logic [DW-1:0] a_out,
   output logic          a_vld_out,
   output logic [DW-1:0] b_out,
   output logic          b_vld_out,
   input  logic [CW-1:0] k_len,
   input  logic          clr,
   output logic [AW-1:0] res_data,
   output logic          res_vld,
   input  logic          res_rdy,
   output logic          busy,
   output logic          ovr,
   output logic          sat,
   output logic [1:0]    state_dbg
);

   // Result port: res_vld/res_data are held until res_vld & res_rdy (handshake) in the same cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

   state_t               state;
   logic signed [AW-1:0] acc;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        klat;

   logic                   pair;
   logic                   hs;
   logic                   start;
   logic [CW-1:0]          k_eff;
   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   prod_ext;
   logic signed [AW-1:0]   acc_add;
   logic                   sat_evt;

   assign pair     = a_vld_in & b_vld_in;
   assign hs       = res_vld & res_rdy;
   assign k_eff    = (k_len == '0) ? CW'(1) : k_len;
   assign prod     = $signed(a_in) * $signed(b_in);
   assign prod_ext = AW'(prod);
   // A new tile begins from IDLE, or from HOLD when the result drains in the same cycle.
   assign start    = pair & ((state == IDLE) | ((state == HOLD) & hs));

`ifdef PE_ACC_SAT_EN
   logic signed [AW:0] sum_w;
   logic               clamp_hold;

   always_comb begin
      sum_w   = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
      sat_evt = 1'b0;
      acc_add = sum_w[AW-1:0];
      if (clamp_hold) begin
         acc_add = acc;
      end else if (sum_w[AW] != sum_w[AW-1]) begin
         sat_evt = 1'b1;
         acc_add = sum_w[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
   end

   // Once clamped, the tile keeps the rail value until it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         clamp_hold <= 1'b0;
      else if (clr | start | (state != ACC))
         clamp_hold <= 1'b0;
      else if (pair & sat_evt)
         clamp_hold <= 1'b1;
   end
`else
   assign acc_add = acc + prod_ext;
   assign sat_evt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out     <= '0;
         a_vld_out <= 1'b0;
         b_out     <= '0;
         b_vld_out <= 1'b0;
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         klat      <= '0;
         res_vld   <= 1'b0;
         ovr       <= 1'b0;
         sat       <= 1'b0;
      end else begin
         a_out     <= a_in;
         a_vld_out <= a_vld_in;
         b_out     <= b_in;
         b_vld_out <= b_vld_in;
         if (clr) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            res_vld <= 1'b0;
            ovr     <= 1'b0;
            sat     <= 1'b0;
         end else if (start) begin
            acc  <= prod_ext;
            cnt  <= CW'(1);
            klat <= k_eff;
            if (k_eff == CW'(1)) begin
               state   <= HOLD;
               res_vld <= 1'b1;
            end else begin
               state   <= ACC;
               res_vld <= 1'b0;
            end
         end else begin
            case (state)
               ACC: if (pair) begin
                  acc <= acc_add;
                  cnt <= cnt + CW'(1);
                  if (sat_evt) sat <= 1'b1;
                  if (cnt + CW'(1) == klat) begin
                     state   <= HOLD;
                     res_vld <= 1'b1;
                  end
               end
               HOLD: if (hs) begin
                  state   <= IDLE;
                  acc     <= '0;
                  cnt     <= '0;
                  res_vld <= 1'b0;
               end else if (pair) begin
                  ovr <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign res_data  = res_vld ? acc : '0;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_pe_os_stream.sv
// Directed bench for pe_os_stream: 24-bit main instance plus a 16-bit instance for the accumulator-limit case.
module tb_pe_os_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_in = '0, b_in = '0;
   logic       a_vld_in = 1'b0, b_vld_in = 1'b0;
   logic [7:0] k_len = '0;
   logic       clr = 1'b0, res_rdy = 1'b0;

   logic [7:0]  a_out, b_out, a_out16, b_out16;
   logic        a_vld_out, b_vld_out, a_vld_out16, b_vld_out16;
   logic [23:0] res_data;
   logic [15:0] res_data16;
   logic        res_vld, res_vld16, busy, busy16, ovr, ovr16, sat, sat16;
   logic [1:0]  state_dbg, state_dbg16;

   int total = 0;
   int bad   = 0;

   pe_os_stream #(.DW(8), .AW(24), .K_MAX(255)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
      .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
      .k_len(k_len), .clr(clr),
      .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
      .busy(busy), .ovr(ovr), .sat(sat), .state_dbg(state_dbg)
   );

   pe_os_stream #(.DW(8), .AW(16), .K_MAX(255)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
      .a_out(a_out16), .a_vld_out(a_vld_out16), .b_out(b_out16), .b_vld_out(b_vld_out16),
      .k_len(k_len), .clr(clr),
      .res_data(res_data16), .res_vld(res_vld16), .res_rdy(res_rdy),
      .busy(busy16), .ovr(ovr16), .sat(sat16), .state_dbg(state_dbg16)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic va, input int av, input logic vb, input int bv);
      a_vld_in = va;
      a_in     = 8'(av);
      b_vld_in = vb;
      b_in     = 8'(bv);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] exp16;
      logic        exp_sat16;

      // 1. reset state, then asynchronous reset in the middle of a tile
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_vld", 32'(res_vld), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      k_len = 8'd4;
      drive(1, 1, 1, 1);
      tick();
      chk("midtile_busy", 32'(busy), 32'd1);
      chk("midtile_a_out", 32'(a_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_a_out", 32'(a_out), 32'd0);
      chk("async_a_vld_out", 32'(a_vld_out), 32'd0);
      drive(0, 0, 0, 0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(state_dbg), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // 2. dot product, k_len=4, res_rdy=1
      res_rdy = 1'b1;
      k_len   = 8'd4;
      drive(1, 3, 1, 4);       tick();
      drive(1, -2, 1, 5);      tick();
      chk("dot_res_vld_early", 32'(res_vld), 32'd0);
      drive(1, 127, 1, 127);   tick();
      drive(1, -128, 1, -128); tick();
      chk("dot_res_vld", 32'(res_vld), 32'd1);
      chk("dot_res_data", 32'(res_data), 32'(12 - 10 + 16129 + 16384));
      drive(0, 0, 0, 0);       tick();
      chk("dot_res_vld_1cyc", 32'(res_vld), 32'd0);
      chk("dot_res_data_zero", 32'(res_data), 32'd0);
      chk("dot_idle", 32'(busy), 32'd0);

      // 3. gaps, single-sided valid, zero operand, k_len=3
      k_len = 8'd3;
      drive(1, 2, 1, 2);  tick();
      drive(0, 0, 0, 0);  tick();
      drive(1, 9, 0, 0);  tick();
      chk("gap_a_out", 32'(a_out), 32'd9);
      chk("gap_a_vld_out", 32'(a_vld_out), 32'd1);
      chk("gap_b_vld_out", 32'(b_vld_out), 32'd0);
      chk("gap_not_done", 32'(res_vld), 32'd0);
      drive(1, 0, 1, 7);  tick();
      chk("gap_zero_pair_not_done", 32'(res_vld), 32'd0);
      drive(1, 1, 1, 1);  tick();
      chk("gap_res_vld", 32'(res_vld), 32'd1);
      chk("gap_res_data", 32'(res_data), 32'd5);
      drive(0, 0, 0, 0);  tick();
      chk("gap_drained", 32'(busy), 32'd0);

      // 4. backpressure, k_len=1
      res_rdy = 1'b0;
      k_len   = 8'd1;
      drive(1, 5, 1, 5);  tick();
      chk("bp_state_hold", 32'(state_dbg), 32'd2);
      chk("bp_res_data", 32'(res_data), 32'd25);
      chk("bp_ovr_clear", 32'(ovr), 32'd0);
      drive(1, 1, 1, 1);  tick();
      chk("bp_ovr_set", 32'(ovr), 32'd1);
      chk("bp_res_data_stable", 32'(res_data), 32'd25);
      res_rdy = 1'b1;
      drive(1, 2, 1, 3);  tick();
      chk("bp_restart_vld", 32'(res_vld), 32'd1);
      chk("bp_restart_data", 32'(res_data), 32'd6);
      chk("bp_ovr_sticky", 32'(ovr), 32'd1);
      res_rdy = 1'b0;
      drive(0, 0, 0, 0);  tick();
      chk("bp_hold_again", 32'(res_data), 32'd6);

      // 5. clr in HOLD discards the result and the same-cycle pair
      clr = 1'b1;
      drive(1, 7, 1, -3); tick();
      chk("clr_res_vld", 32'(res_vld), 32'd0);
      chk("clr_res_data", 32'(res_data), 32'd0);
      chk("clr_ovr", 32'(ovr), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_a_out", 32'(a_out), 32'd7);
      chk("clr_b_out", 32'(b_out), 32'(8'hFD));
      clr = 1'b0;
      drive(0, 0, 0, 0);  tick();
      chk("clr_pair_discarded", 32'(busy), 32'd0);
      chk("clr_b_vld_out", 32'(b_vld_out), 32'd0);

      // 6. accumulator limit on the 16-bit instance, 3 x (127,127) = 48387
`ifdef PE_ACC_SAT_EN
      exp16     = 32'd32767;
      exp_sat16 = 1'b1;
`else
      exp16     = 32'd48387;   // -17149 as a 16-bit pattern
      exp_sat16 = 1'b0;
`endif
      k_len = 8'd3;
      repeat (3) begin
         drive(1, 127, 1, 127);
         tick();
      end
      drive(0, 0, 0, 0);
      chk("lim16_res_vld", 32'(res_vld16), 32'd1);
      chk("lim16_res_data", 32'(res_data16), exp16);
      chk("lim16_sat", 32'(sat16), 32'(exp_sat16));
      chk("lim24_res_data", 32'(res_data), 32'd48387);
      chk("lim24_sat", 32'(sat), 32'd0);
      res_rdy = 1'b1;
      tick();
      chk("lim16_drained", 32'(res_vld16), 32'd0);
      chk("lim16_sat_sticky", 32'(sat16), 32'(exp_sat16));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
